mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute, memory and writeback over several cycles.
- Sits beside a multicycle datapath with a shared instruction/data memory port.
- Adds over the single-cycle controller: a memory ready handshake with wait states, a bounded memory timeout, bne/jr support, a sticky trap on illegal encodings, and a parametrised ALU-control width.

Parameters:
ALUCTRL_W, 3, alucontrol width (>=3); codes zero-extended above bit 2
MEM_TIMEOUT, 255, max cycles waiting for mem_ready per access; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
iord  out  1  0=PC address, 1=ALUOut address
memwrite  out  1  store strobe
irwrite  out  1  load instruction register
pcen  out  1  PC write enable
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 register A (jr)
alusrca  out  1  0=PC, 1=A
alusrcb  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
regdst  out  1  0=rt, 1=rd
memtoreg  out  1  writeback from data register
regwrite  out  1  register file write
alucontrol  out  ALUCTRL_W  ALU operation
trap  out  1  sticky illegal instruction or bus timeout
state_dbg  out  4  current state encoding

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, JR, TRAP.
- Reset (async): state=FETCH, wait counter=0. While reset=1, mem_req, memwrite, irwrite, pcen and regwrite are forced to 0. All other outputs are 0 except FETCH statics: alusrcb=01, alucontrol=add.
- All outputs decode from the registered state. Exceptions: pcen, irwrite and the BRANCH condition also depend on mem_ready/zero in the same cycle.
- ALU codes: add=010, sub=110, and=000, or=001, slt=111.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - Hold until mem_ready=1.
  - That cycle: irwrite=1, pcen=1, next state DECODE.
- DECODE: alusrca=0, alusrcb=11, add (branch target to ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 with funct 001000 -> JR
  - 000000 with a legal funct (100000, 100010, 100100, 100101, 101010) -> EXEC
  - 000100 or 000101 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op or funct -> TRAP
- MEMADR: alusrca=1, alusrcb=10, add. Next MEMRD if op=lw, else MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_ready -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Next FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. On mem_ready -> FETCH. memwrite stays high through wait cycles.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct. Next ALUWB.
- ALUWB: regwrite=1, regdst=1. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for beq, ~zero for bne.
  - Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next ADDIWB.
- ADDIWB: regwrite=1, regdst=0. Next FETCH.
- JUMP: pcsrc=10, pcen=1. Next FETCH.
- JR: pcsrc=11, pcen=1. Next FETCH.
- Latency with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j/jr 3 cycles.
- Each memory wait adds one cycle.
- Timeout counter:
  - Counts cycles in FETCH/MEMRD/MEMWR with mem_ready=0.
  - Clears on mem_ready=1 and on entry to a memory state.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP. memwrite is not asserted in TRAP.
  - Counter width is clog2(MEM_TIMEOUT+1), saturating.
- TRAP: trap=1, all strobes 0. Held until reset.
- mem_ready=1 while mem_req=0 is ignored.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - funct constants, including F_JR
  - the 3-bit ALU code constants
- One sub-module, mc_aludec: combinational funct/aluop-to-alucontrol decode, parametrised by ALUCTRL_W, with a legal-funct output used by DECODE.

Test Plan:
- lw, mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5; irwrite=1 only in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; no trap.
- beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH. bne with zero=1 -> pcen=0. bne with zero=0 -> pcen=1.
- R-type funct 101010 -> alucontrol=111 in EXEC, regdst=1 in ALUWB. funct 001000 -> JR with pcsrc=11, pcen=1.
- op=111111 -> TRAP after DECODE; trap stays 1 for 20 cycles; async reset mid-cycle -> FETCH and trap=0 immediately.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP entered on cycle 5, pcen never asserted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        JR      = 4'd12,
        TRAP    = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU-control decode from aluop/funct; legal flags the R-type functs the ALU implements.
module mc_aludec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  aluop_t               aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 legal
);

    logic [2:0] fcode;
    logic [2:0] code;

    always_comb begin
        fcode = ALU_ADD;
        legal = 1'b1;
        case (funct)
            F_ADD:   fcode = ALU_ADD;
            F_SUB:   fcode = ALU_SUB;
            F_AND:   fcode = ALU_AND;
            F_OR:    fcode = ALU_OR;
            F_SLT:   fcode = ALU_SLT;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   code = ALU_SUB;
            ALUOP_FUNCT: code = fcode;
            default:     code = ALU_ADD;
        endcase
        // Wider ALU buses see the 3-bit code zero-extended.
        alucontrol      = '0;
        alucontrol[2:0] = code;
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS Moore controller with memory wait states, access timeout and sticky trap.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 3,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 pcen,
    output logic [1:0]           pcsrc,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 trap,
    output logic [3:0]           state_dbg
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT) : '1;

    state_t           state, state_next;
    aluop_t           aluop;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_mem, timeout, funct_legal;
    logic             mem_req_s, memwrite_s, irwrite_s, pcen_s, regwrite_s;

    mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol),
        .legal      (funct_legal)
    );

    assign in_mem  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    // Fires on the wait cycle that brings the count up to MEM_TIMEOUT.
    assign timeout = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (!in_mem || mem_ready) wait_cnt <= '0;
            else if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        mem_req_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        pcen_s     = 1'b0;
        regwrite_s = 1'b0;
        iord       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        aluop      = ALUOP_ADD;
        trap       = 1'b0;
        case (state)
            FETCH: begin
                mem_req_s = 1'b1;
                alusrcb   = 2'b01;
                if (mem_ready) begin
                    irwrite_s  = 1'b1;
                    pcen_s     = 1'b1;
                    state_next = DECODE;
                end else if (timeout) state_next = TRAP;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:   state_next = MEMADR;
                    OP_RTYPE: begin
                        if (funct == F_JR)    state_next = JR;
                        else if (funct_legal) state_next = EXEC;
                        else                  state_next = TRAP;
                    end
                    OP_BEQ, OP_BNE: state_next = BRANCH;
                    OP_ADDI:        state_next = ADDIEX;
                    OP_J:           state_next = JUMP;
                    default:        state_next = TRAP;
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req_s = 1'b1;
                iord      = 1'b1;
                if (mem_ready)    state_next = MEMWB;
                else if (timeout) state_next = TRAP;
            end
            MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                mem_req_s  = 1'b1;
                iord       = 1'b1;
                memwrite_s = 1'b1;
                if (mem_ready)    state_next = FETCH;
                else if (timeout) state_next = TRAP;
            end
            EXEC: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                regwrite_s = 1'b1;
                regdst     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                pcen_s     = (op == OP_BNE) ? !zero : zero;
                state_next = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pcen_s     = 1'b1;
                state_next = FETCH;
            end
            JR: begin
                pcsrc      = 2'b11;
                pcen_s     = 1'b1;
                state_next = FETCH;
            end
            default: begin
                trap       = 1'b1;
                state_next = TRAP;
            end
        endcase
    end

    // Strobes are held low for the whole reset pulse, not just after the edge.
    assign mem_req   = mem_req_s  & ~reset;
    assign memwrite  = memwrite_s & ~reset;
    assign irwrite   = irwrite_s  & ~reset;
    assign pcen      = pcen_s     & ~reset;
    assign regwrite  = regwrite_s & ~reset;
    assign state_dbg = state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction sequences, wait states, trap and timeout.
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset, rst2;
    logic [5:0] op, funct, op2, funct2;
    logic       zero, mem_ready, zero2, mem_ready2;

    logic       mem_req, iord, memwrite, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, trap;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state_dbg;

    logic       mem_req2, iord2, memwrite2, irwrite2, pcen2, alusrca2, regdst2, memtoreg2, regwrite2, trap2;
    logic [1:0] pcsrc2, alusrcb2;
    logic [3:0] alucontrol2;
    logic [3:0] state_dbg2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mc_controller u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alucontrol(alucontrol), .trap(trap),
        .state_dbg(state_dbg)
    );

    mc_controller #(.ALUCTRL_W(4), .MEM_TIMEOUT(4)) u_to (
        .clk(clk), .reset(rst2), .op(op2), .funct(funct2), .zero(zero2), .mem_ready(mem_ready2),
        .mem_req(mem_req2), .iord(iord2), .memwrite(memwrite2), .irwrite(irwrite2), .pcen(pcen2),
        .pcsrc(pcsrc2), .alusrca(alusrca2), .alusrcb(alusrcb2), .regdst(regdst2),
        .memtoreg(memtoreg2), .regwrite(regwrite2), .alucontrol(alucontrol2), .trap(trap2),
        .state_dbg(state_dbg2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs FETCH (zero-wait) and DECODE for one instruction; returns in the third state.
    task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f);
        op = o;
        funct = f;
        mem_ready = 1'b1;
        #1;
        check("fetch_state", state_dbg, FETCH);
        check("fetch_irwrite", irwrite, 1'b1);
        check("fetch_pcen", pcen, 1'b1);
        tick();
        check("decode_state", state_dbg, DECODE);
        check("decode_alusrcb", alusrcb, 2'b11);
        check("decode_irwrite", irwrite, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b0; rst2 = 1'b0;
        op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        op2 = '0; funct2 = '0; zero2 = 1'b0; mem_ready2 = 1'b0;
        #1;
        reset = 1'b1; rst2 = 1'b1;
        #2;
        check("rst_state", state_dbg, FETCH);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_pcen", pcen, 1'b0);
        check("rst_irwrite", irwrite, 1'b0);
        check("rst_alusrcb", alusrcb, 2'b01);
        check("rst_alucontrol", alucontrol, 3'b010);
        check("rst_trap", trap, 1'b0);
        check("rst_alucontrol_w4", alucontrol2, 4'b0010);
        tick();
        reset = 1'b0;

        // lw, zero-wait: five states
        fetch_decode(OP_LW, 6'b000000);
        check("lw_memadr", state_dbg, MEMADR);
        check("lw_memadr_srcb", alusrcb, 2'b10);
        tick();
        check("lw_memrd", state_dbg, MEMRD);
        check("lw_memrd_iord", iord, 1'b1);
        check("lw_memrd_irwrite", irwrite, 1'b0);
        tick();
        check("lw_memwb", state_dbg, MEMWB);
        check("lw_regwrite", regwrite, 1'b1);
        check("lw_memtoreg", memtoreg, 1'b1);
        tick();

        // sw with three wait cycles in MEMWR
        fetch_decode(OP_SW, 6'b000000);
        check("sw_memadr", state_dbg, MEMADR);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("sw_memwr_state", state_dbg, MEMWR);
            check("sw_memwrite", memwrite, 1'b1);
            tick();
        end
        check("sw_back_fetch", state_dbg, FETCH);
        check("sw_no_trap", trap, 1'b0);

        // branches
        zero = 1'b1;
        fetch_decode(OP_BEQ, 6'b000000);
        check("beq_state", state_dbg, BRANCH);
        check("beq_z1_pcen", pcen, 1'b1);
        check("beq_pcsrc", pcsrc, 2'b01);
        check("beq_alucontrol", alucontrol, 3'b110);
        tick();
        fetch_decode(OP_BNE, 6'b000000);
        check("bne_z1_pcen", pcen, 1'b0);
        tick();
        zero = 1'b0;
        fetch_decode(OP_BNE, 6'b000000);
        check("bne_z0_pcen", pcen, 1'b1);
        tick();

        // R-type slt
        fetch_decode(OP_RTYPE, F_SLT);
        check("slt_exec", state_dbg, EXEC);
        check("slt_alucontrol", alucontrol, 3'b111);
        check("slt_alusrca", alusrca, 1'b1);
        tick();
        check("slt_aluwb", state_dbg, ALUWB);
        check("slt_regdst", regdst, 1'b1);
        check("slt_regwrite", regwrite, 1'b1);
        tick();

        // jr and j
        fetch_decode(OP_RTYPE, F_JR);
        check("jr_state", state_dbg, JR);
        check("jr_pcsrc", pcsrc, 2'b11);
        check("jr_pcen", pcen, 1'b1);
        tick();
        fetch_decode(OP_J, 6'b000000);
        check("j_state", state_dbg, JUMP);
        check("j_pcsrc", pcsrc, 2'b10);
        tick();

        // addi
        fetch_decode(OP_ADDI, 6'b000000);
        check("addi_ex", state_dbg, ADDIEX);
        check("addi_ex_srcb", alusrcb, 2'b10);
        tick();
        check("addi_wb", state_dbg, ADDIWB);
        check("addi_regdst", regdst, 1'b0);
        check("addi_regwrite", regwrite, 1'b1);
        tick();
        check("addi_back_fetch", state_dbg, FETCH);

        // illegal op: sticky trap
        fetch_decode(6'b111111, 6'b000000);
        for (int i = 0; i < 20; i++) begin
            check("trap_state", state_dbg, TRAP);
            check("trap_flag", trap, 1'b1);
            check("trap_mem_req", mem_req, 1'b0);
            tick();
        end
        #2;
        reset = 1'b1;
        #1;
        check("midrst_state", state_dbg, FETCH);
        check("midrst_trap", trap, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_mem_req", mem_req, 1'b1);

        // illegal funct under op 0
        fetch_decode(OP_RTYPE, 6'b000001);
        check("bad_funct_trap", state_dbg, TRAP);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // timeout instance: mem_ready held low in FETCH
        rst2 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("to_fetch_state", state_dbg2, FETCH);
            check("to_pcen", pcen2, 1'b0);
            check("to_no_trap", trap2, 1'b0);
            tick();
        end
        check("to_trap_state", state_dbg2, TRAP);
        check("to_trap_flag", trap2, 1'b1);
        check("to_pcen_trap", pcen2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
